attn_job_initiator: RTL and testbench

ATTN_JOB_INITIATOR -- requirements
Module: attn_job_initiator

---
 rtl/attn_job_initiator.sv | 164 ++++++++++++++++
 tb/tb_attn_job_initiator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/attn_job_initiator.sv
// rtl/attn_job_initiator.sv - one-shot attention job launcher that buffers the result and streams it out
// Optional watchdog on the accelerator wait: define ATTN_JOB_TIMEOUT_EN.
module attn_job_initiator #(
    parameter int DATA_WIDTH  = 16,
    parameter int L           = 16,
    parameter int E           = 32,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    output logic                  acc_start,
    input  logic                  acc_done,
    input  logic [DATA_WIDTH-1:0] acc_out [L*E],
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  err_timeout
);
    localparam int N  = L * E;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_STREAM,
        S_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d, idx_nx;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                    m_last_q, m_last_d;
    logic                    job_ready_q, acc_start_q, m_valid_q, busy_q;
    logic                    capture;
    logic [DATA_WIDTH-1:0]   word_q [N];

`ifdef ATTN_JOB_TIMEOUT_EN
    localparam logic [23:0] TMO = 24'(TIMEOUT_CYC);
    logic [23:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        m_data_d = m_data_q;
        m_last_d = m_last_q;
        capture  = 1'b0;
        idx_nx   = idx_q + 1'b1;
`ifdef ATTN_JOB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (job_valid && job_ready_q) begin
                    state_d = S_START;
`ifdef ATTN_JOB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef ATTN_JOB_TIMEOUT_EN
                cnt_d   = 24'd1;
`endif
            end
            S_WAIT: begin
                // acc_done beats the watchdog when both land in the same cycle
                if (acc_done) begin
                    capture  = 1'b1;
                    state_d  = S_STREAM;
                    idx_d    = '0;
                    m_data_d = acc_out[0];
                    m_last_d = (N == 1);
                end
`ifdef ATTN_JOB_TIMEOUT_EN
                else if (cnt_q == TMO) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
`endif
            end
            S_STREAM: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d  = S_IDLE;
                        idx_d    = '0;
                        m_last_d = 1'b0;
                    end else begin
                        idx_d    = idx_nx;
                        m_data_d = word_q[idx_nx];
                        m_last_d = (idx_nx == LAST_IDX);
                    end
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            job_ready_q <= 1'b1;
            acc_start_q <= 1'b0;
            m_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ATTN_JOB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            job_ready_q <= (state_d == S_IDLE);
            acc_start_q <= (state_d == S_START);
            m_valid_q   <= (state_d == S_STREAM);
            busy_q      <= (state_d != S_IDLE);
`ifdef ATTN_JOB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Result snapshot is frozen for the whole stream; no reset needed.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < N; k++) begin
                word_q[k] <= acc_out[k];
            end
        end
    end

    assign job_ready = job_ready_q;
    assign acc_start = acc_start_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;

`ifdef ATTN_JOB_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    // Low for every legal TIMEOUT_CYC; the watchdog is not built.
    assign err_timeout = (TIMEOUT_CYC < 1);
`endif

endmodule

// File: tb/tb_attn_job_initiator.sv
// tb/tb_attn_job_initiator.sv - directed scoreboard bench for attn_job_initiator (L=2, E=4, TIMEOUT_CYC=20)
module tb_attn_job_initiator;
    localparam int DW  = 16;
    localparam int L   = 2;
    localparam int E   = 4;
    localparam int N   = L * E;
    localparam int TMO = 20;

    logic          clk;
    logic          rst;
    logic          job_valid;
    logic          job_ready;
    logic          acc_start;
    logic          acc_done;
    logic [DW-1:0] acc_out [N];
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          err_timeout;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] exp_q [$];

    attn_job_initiator #(
        .DATA_WIDTH (DW),
        .L          (L),
        .E          (E),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .acc_start  (acc_start),
        .acc_done   (acc_done),
        .acc_out    (acc_out),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_result(input logic [DW-1:0] base);
        for (int i = 0; i < N; i++) begin
            acc_out[i] = base + DW'(i);
            exp_q.push_back(base + DW'(i));
        end
    endtask

    // Called in the cycle after acc_done; m_valid must be high until the last handshake.
    task automatic drain(input bit toggle, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            m_ready = toggle ? (c % 2 == 0) : 1'b1;
            chk("m_valid_in_stream", m_valid, 1);
            chk("m_data", m_data, exp_q[0]);
            chk("m_last", m_last, exp_q.size() == 1);
            chk("acc_start_in_stream", acc_start, 0);
            if (m_valid && m_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) done = 1'b1;
            end
            tick;
        end
        if (!done) chk("drain_budget", exp_q.size(), 0);
        m_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        job_valid = 1'b0;
        acc_done  = 1'b0;
        m_ready   = 1'b1;
        for (int i = 0; i < N; i++) acc_out[i] = '0;

        repeat (2) tick;
        chk("rst_job_ready", job_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_acc_start", acc_start, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b0;

        // Basic job: accept in cycle 0, acc_done in cycle 10, stream cycles 11..18
        job_valid = 1'b1;
        tick;
        job_valid = 1'b0;
        chk("t1_acc_start_c1", acc_start, 1);
        chk("t1_busy_c1", busy, 1);
        chk("t1_job_ready_c1", job_ready, 0);
        tick;
        chk("t1_acc_start_c2", acc_start, 0);
        repeat (8) tick;
        chk("t1_m_valid_c10", m_valid, 0);
        acc_done = 1'b1;
        load_result(16'h0001);
        tick;
        acc_done = 1'b0;
        drain(1'b0, 8);
        chk("t1_job_ready_c19", job_ready, 1);
        chk("t1_busy_c19", busy, 0);
        chk("t1_m_valid_c19", m_valid, 0);
        chk("t1_m_last_c19", m_last, 0);

        // Back-pressure plus acc_out overwritten during the stream
        job_valid = 1'b1;
        tick;
        job_valid = 1'b0;
        chk("t2_acc_start", acc_start, 1);
        repeat (3) tick;
        acc_done = 1'b1;
        load_result(16'h0001);
        tick;
        acc_done = 1'b0;
        for (int i = 0; i < N; i++) acc_out[i] = 16'hFFFF;
        drain(1'b1, 40);
        chk("t2_m_valid_after", m_valid, 0);
        chk("t2_job_ready_after", job_ready, 1);

        // job_valid held high across a whole job
        job_valid = 1'b1;
        tick;
        chk("t3_first_start", acc_start, 1);
        tick;
        for (int i = 0; i < 4; i++) begin
            chk("t3_no_restart", acc_start, 0);
            chk("t3_job_ready_busy", job_ready, 0);
            tick;
        end
        acc_done = 1'b1;
        load_result(16'h0010);
        tick;
        acc_done = 1'b0;
        drain(1'b0, 20);
        chk("t3_idle_after_last", job_ready, 1);
        chk("t3_no_early_start", acc_start, 0);
        tick;
        chk("t3_second_start", acc_start, 1);
        job_valid = 1'b0;
        tick;
        acc_done = 1'b1;
        load_result(16'h0020);
        tick;
        acc_done = 1'b0;
        drain(1'b0, 20);

`ifdef ATTN_JOB_TIMEOUT_EN
        // Watchdog expiry, then a job whose acc_done lands on the expiry cycle
        job_valid = 1'b1;
        tick;
        job_valid = 1'b0;
        tick;
        repeat (TMO - 1) tick;
        chk("t4_err_before", err_timeout, 0);
        chk("t4_busy_before", busy, 1);
        tick;
        chk("t4_err_set", err_timeout, 1);
        chk("t4_job_ready_err", job_ready, 0);
        tick;
        chk("t4_busy_idle", busy, 0);
        chk("t4_job_ready_idle", job_ready, 1);
        chk("t4_err_sticky", err_timeout, 1);
        job_valid = 1'b1;
        tick;
        job_valid = 1'b0;
        chk("t4_err_cleared", err_timeout, 0);
        tick;
        repeat (TMO - 1) tick;
        acc_done = 1'b1;
        load_result(16'h0030);
        tick;
        acc_done = 1'b0;
        chk("t4_err_race", err_timeout, 0);
        drain(1'b0, 20);
`else
        // Without the watchdog the wait is unbounded
        job_valid = 1'b1;
        tick;
        job_valid = 1'b0;
        repeat (2 * TMO) tick;
        chk("t4_err_tied", err_timeout, 0);
        chk("t4_still_busy", busy, 1);
        chk("t4_no_stream", m_valid, 0);
        acc_done = 1'b1;
        load_result(16'h0030);
        tick;
        acc_done = 1'b0;
        drain(1'b0, 20);
`endif

        // Reset in the middle of a stream, then a stray acc_done
        job_valid = 1'b1;
        tick;
        job_valid = 1'b0;
        repeat (3) tick;
        acc_done = 1'b1;
        load_result(16'h0100);
        tick;
        acc_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_pre_rst_valid", m_valid, 1);
            chk("t5_pre_rst_data", m_data, exp_q.pop_front());
            tick;
        end
        rst = 1'b1;
        #1;
        chk("t5_rst_m_valid", m_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_job_ready", job_ready, 1);
        exp_q.delete();
        tick;
        rst = 1'b0;
        acc_done = 1'b1;
        tick;
        acc_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t5_late_done_valid", m_valid, 0);
            chk("t5_late_done_busy", busy, 0);
            tick;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
